// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with a two-entry skid buffer.
//
// Holds up to two DW-bit payloads in FIFO order. The head sits in the main
// register and drives out_data directly. A second payload, accepted while the
// head is blocked, waits in the skid register. in_ready comes straight from a
// flop, so there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk        clock, all state updates on posedge
//   clr        synchronous active-high reset (highest priority)
//   flush      synchronous kill of all held entries (below clr)
//   in_valid   upstream has a payload
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  stage holds a payload for downstream
//   out_ready  downstream accepts
//   out_data   head payload (main register)
//   occ        occupancy 0..2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
//              (present only when PIPE_STALL_CNT_EN is defined)
//
// Optional feature macro: PIPE_STALL_CNT_EN.

module pipe_skid_stage #(
  parameter int unsigned    DW        = 64,
  parameter logic [DW-1:0]  RESET_VAL = '0,
  parameter int unsigned    CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        occ
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Elaboration-time parameter sanity checks.
  if (DW < 1) begin : gen_dw_check
    $error("pipe_skid_stage: DW must be >= 1");
  end
  if (CNT_W < 1) begin : gen_cnt_w_check
    $error("pipe_skid_stage: CNT_W must be >= 1");
  end

  // Encoding chosen so the state value is the occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            in_ready_q;

  logic            in_fire;
  logic            out_fire;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occ       = state_q;

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Handshakes in this cycle still complete; the payloads are discarded.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StBusy;
            main_d  = in_data;
          end
        end
        StBusy: begin
          if (in_fire && out_fire) begin
            main_d  = in_data;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d = StBusy;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StEmpty;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered from next state so it always equals (state != FULL).
      in_ready_q <= (state_d != StFull);
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Cleared only by clr; flush leaves the statistic intact.
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
